// File: rtl/w4823_fir_pkg.sv
// Constants and state type shared between the W4823 FIR and its coefficient load sequencer.
package w4823_fir_pkg;

    localparam int unsigned N_TAPS = 64;
    localparam int unsigned CW     = 17;
    localparam int unsigned AW     = $clog2(N_TAPS);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StWrite,
        StGap,
        StDone
    } cload_state_t;

endpackage

// File: rtl/w4823_fir_cload.sv
// Coefficient load sequencer: streams ntaps words into FIR coefficient addresses 0..ntaps-1,
// spacing writes by GAP idle cycles, with a done pulse and a sticky error on abort or bad length.
module w4823_fir_cload
    import w4823_fir_pkg::*;
#(
    parameter int unsigned N_TAPS = w4823_fir_pkg::N_TAPS,
    parameter int unsigned CW     = w4823_fir_pkg::CW,
    parameter int unsigned AW     = w4823_fir_pkg::AW,
    parameter int unsigned GAP    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   ntaps,
    input  logic          abort,
    input  logic [CW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [CW-1:0] cin,
    output logic [AW-1:0] caddr,
    output logic          cload,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // Gap counter holds GAP-1 down to 0, so it needs clog2(GAP) bits (at least one).
    localparam int unsigned    GW       = (GAP < 2) ? 1 : $clog2(GAP);
    localparam logic [GW-1:0]  GAP_LOAD = GW'((GAP == 0) ? 0 : GAP - 1);
    localparam logic [AW:0]    MAX_N    = (AW + 1)'(N_TAPS);

    cload_state_t  r_state;
    logic [AW:0]   r_ntaps;
    logic [AW-1:0] r_addr;
    logic [GW-1:0] r_gap;
    logic [CW-1:0] r_cin;
    logic [AW-1:0] r_caddr;
    logic          r_cload;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          w_last;

    // abort wins over a same-cycle handshake by withdrawing ready.
    assign s_ready = (r_state == StWait) && !abort;
    assign w_last  = ({1'b0, r_addr} == (r_ntaps - (AW + 1)'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_ntaps <= '0;
            r_addr  <= '0;
            r_gap   <= '0;
            r_cin   <= '0;
            r_caddr <= '0;
            r_cload <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cload <= 1'b0;
            r_done  <= 1'b0;
            if (abort && (r_state != StIdle)) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (start) begin
                            if ((ntaps == '0) || (ntaps > MAX_N)) begin
                                r_err <= 1'b1;
                            end else begin
                                r_err   <= 1'b0;
                                r_ntaps <= ntaps;
                                r_addr  <= '0;
                                r_busy  <= 1'b1;
                                r_state <= StWait;
                            end
                        end
                    end
                    StWait: begin
                        if (s_valid && s_ready) begin
                            r_cin   <= s_data;
                            r_caddr <= r_addr;
                            r_cload <= 1'b1;
                            r_state <= StWrite;
                        end
                    end
                    StWrite: begin
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_addr <= r_addr + AW'(1);
                            if (GAP == 0) begin
                                r_state <= StWait;
                            end else begin
                                r_gap   <= GAP_LOAD;
                                r_state <= StGap;
                            end
                        end
                    end
                    StGap: begin
                        if (r_gap == '0) begin
                            r_state <= StWait;
                        end else begin
                            r_gap <= r_gap - GW'(1);
                        end
                    end
                    StDone: begin
                        r_state <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign cin   = r_cin;
    assign caddr = r_caddr;
    assign cload = r_cload;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_w4823_fir_cload.sv
// Self-checking bench for w4823_fir_cload: directed scenarios with random data and stream gaps,
// checked against write timing and ordering derived from the load rules.
module tb_w4823_fir_cload;

    localparam int NT  = 64;
    localparam int CWT = 17;
    localparam int AWT = 6;
    localparam int GP  = 2;
    localparam int PER = GP + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AWT:0]     ntaps;
    logic             abort;
    logic [CWT-1:0]   s_data;
    logic             s_valid;
    logic             s_ready;
    logic [CWT-1:0]   cin;
    logic [AWT-1:0]   caddr;
    logic             cload;
    logic             busy;
    logic             done;
    logic             err;

    w4823_fir_cload #(
        .N_TAPS (NT),
        .CW     (CWT),
        .AW     (AWT),
        .GAP    (GP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ntaps   (ntaps),
        .abort   (abort),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .cin     (cin),
        .caddr   (caddr),
        .cload   (cload),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed FIR-side writes and done pulses, never cleared; tests use base indices.
    logic [AWT-1:0] cl_addr[$];
    logic [CWT-1:0] cl_data[$];
    int             cl_cyc[$];
    int             done_cyc[$];

    always @(negedge clk) begin
        if (cload) begin
            cl_addr.push_back(caddr);
            cl_data.push_back(cin);
            cl_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
    end

    int n_pass = 0;
    int n_total = 0;

    logic [CWT-1:0] words[$];
    int             widx;
    bit             rand_valid;
    int             t0;
    int             base_cl;
    int             base_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; the source advances on a handshake seen just before the edge.
    task automatic tick();
        bit hs;
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (hs) widx++;
        s_valid = (widx < words.size()) && (!rand_valid || ($urandom_range(0, 2) != 0));
        s_data  = (widx < words.size()) ? words[widx] : '0;
    endtask

    task automatic start_load(input int n);
        widx      = 0;
        base_cl   = cl_addr.size();
        base_done = done_cyc.size();
        t0        = cyc;
        s_valid   = (words.size() > 0);
        s_data    = (words.size() > 0) ? words[0] : '0;
        ntaps     = (AWT + 1)'(n);
        start     = 1'b1;
    endtask

    task automatic run_until_done(input int budget);
        int d0;
        d0 = done_cyc.size();
        for (int i = 0; i < budget && done_cyc.size() == d0; i++) tick();
        tick();
        tick();
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(CWT'($urandom));
    endtask

    initial begin
        logic [31:0] busy_obs;
        logic [31:0] busy_exp;
        int          bad_a;
        int          bad_d;
        int          min_sp;

        rst = 1'b1; start = 1'b0; ntaps = '0; abort = 1'b0;
        s_data = '0; s_valid = 1'b0; rand_valid = 1'b0; widx = 0;
        #1;
        check("reset outputs", {cin, caddr, cload, busy, done, err, s_ready}, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Normal load, three words, valid held high.
        words.delete();
        words.push_back(17'h00001);
        words.push_back(17'h1ABCD);
        words.push_back(17'h1FFFF);
        start_load(3);
        busy_obs = '0;
        busy_obs[0] = busy;
        tick();
        start = 1'b0;
        for (int c = 1; c < 16; c++) begin
            busy_obs[c] = busy;
            tick();
        end
        busy_exp = '0;
        for (int c = 1; c <= 2 + 2 * PER; c++) busy_exp[c] = 1'b1;
        check("normal cload count", 64'(cl_addr.size() - base_cl), 3);
        for (int k = 0; k < 3; k++) begin
            if (base_cl + k < cl_addr.size()) begin
                check($sformatf("normal cload cycle %0d", k), 64'(cl_cyc[base_cl + k] - t0),
                      64'(2 + k * PER));
                check($sformatf("normal caddr %0d", k), 64'(cl_addr[base_cl + k]), 64'(k));
                check($sformatf("normal cin %0d", k), 64'(cl_data[base_cl + k]), 64'(words[k]));
            end
        end
        check("normal done count", 64'(done_cyc.size() - base_done), 1);
        if (done_cyc.size() > base_done)
            check("normal done cycle", 64'(done_cyc[base_done] - t0), 64'(3 + 2 * PER));
        check("normal busy profile", 64'(busy_obs), 64'(busy_exp));

        // Full depth with random data and random stream gaps.
        fill_random(NT + 3);
        rand_valid = 1'b1;
        start_load(NT);
        tick();
        start = 1'b0;
        run_until_done(4000);
        rand_valid = 1'b0;
        check("full cload count", 64'(cl_addr.size() - base_cl), NT);
        bad_a = 0;
        bad_d = 0;
        min_sp = 1000;
        for (int k = 0; k < NT && base_cl + k < cl_addr.size(); k++) begin
            if (cl_addr[base_cl + k] != AWT'(k)) bad_a++;
            if (cl_data[base_cl + k] != words[k]) bad_d++;
            if (k > 0 && (cl_cyc[base_cl + k] - cl_cyc[base_cl + k - 1]) < min_sp)
                min_sp = cl_cyc[base_cl + k] - cl_cyc[base_cl + k - 1];
        end
        check("full caddr order errors", 64'(bad_a), 0);
        check("full cin errors", 64'(bad_d), 0);
        check("full min write spacing ok", 64'(min_sp >= PER), 1);
        check("full done count", 64'(done_cyc.size() - base_done), 1);
        check("full words consumed", 64'(widx), NT);
        check("full idle after", {busy, s_ready}, 0);

        // Bad lengths, then a valid one-word load clears err.
        fill_random(2);
        start_load(0);
        tick();
        start = 1'b0;
        check("len0 err/busy/ready", {err, busy, s_ready}, 3'b100);
        tick();
        ntaps = (AWT + 1)'(NT + 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("len65 err/busy/ready", {err, busy, s_ready}, 3'b100);
        tick();
        check("bad len no cload", 64'(cl_addr.size() - base_cl), 0);
        start_load(1);
        tick();
        start = 1'b0;
        check("len1 err cleared, busy", {err, busy}, 2'b01);
        run_until_done(50);
        check("len1 cload count", 64'(cl_addr.size() - base_cl), 1);
        if (cl_addr.size() > base_cl)
            check("len1 write", {cl_addr[base_cl], cl_data[base_cl]}, {6'd0, words[0]});
        check("len1 done count", 64'(done_cyc.size() - base_done), 1);

        // Abort colliding with a handshake in the second WAIT.
        fill_random(3);
        start_load(3);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2 + GP; i++) tick();
        check("abort pre ready/valid", {s_ready, s_valid}, 2'b11);
        abort = 1'b1;
        #1;
        check("abort forces ready low", 64'(s_ready), 0);
        tick();
        abort = 1'b0;
        check("abort err/busy", {err, busy}, 2'b10);
        for (int i = 0; i < 6; i++) tick();
        check("abort cload count", 64'(cl_addr.size() - base_cl), 1);
        check("abort no done", 64'(done_cyc.size() - base_done), 0);
        check("abort word not consumed", 64'(widx), 1);

        // Asynchronous reset during GAP, then a fresh load restarts at address 0.
        fill_random(3);
        start_load(3);
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre-reset busy in gap", {busy, s_ready, cload}, 3'b100);
        #2;
        rst = 1'b1;
        #1;
        check("reset mid-load outputs", {cin, caddr, cload, busy, done, err, s_ready}, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        fill_random(2);
        start_load(2);
        tick();
        start = 1'b0;
        run_until_done(50);
        check("restart cload count", 64'(cl_addr.size() - base_cl), 2);
        for (int k = 0; k < 2 && base_cl + k < cl_addr.size(); k++)
            check($sformatf("restart write %0d", k), {cl_addr[base_cl + k], cl_data[base_cl + k]},
                  {AWT'(k), words[k]});

        // Start pulsed while busy is ignored.
        fill_random(5);
        start_load(2);
        tick();
        start = 1'b0;
        tick();
        tick();
        ntaps = 7'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done(80);
        check("ignored start cload count", 64'(cl_addr.size() - base_cl), 2);
        check("ignored start done count", 64'(done_cyc.size() - base_done), 1);
        if (cl_addr.size() > base_cl + 1)
            check("ignored start last caddr", 64'(cl_addr[base_cl + 1]), 1);
        check("ignored start idle after", {busy, s_ready, err}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
